count_ctrl: RTL and testbench

- Command controller for the single-digit display counter.
- Takes raw pushbuttons and switches, then synchronizes, debounces and edge-detects each one.
- Arbitrates simultaneous requests and sequences one count operation per accepted press.
- Drives the count register that feeds the 7-segment decoder, plus step/wrap status pulses for downstream logic.

---
 rtl/count_ctrl.sv | 178 +++++++++++++++++
 tb/tb_count_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// count_ctrl: command controller for the single-digit display counter.
// Each raw button is synchronized, debounced and edge-detected. Same-cycle
// presses are arbitrated CLR > LOAD > UP > DOWN, and one count operation is
// executed per accepted press. step/wrap are status pulses for downstream logic.
// Optional build macro: AUTO_REPEAT_EN adds hold-to-repeat on the UP/DOWN buttons.
module count_ctrl #(
    parameter int DEBOUNCE_TIME = 25,
    parameter int MAX_COUNT     = 9,
    parameter int REPEAT_TIME   = 200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_clr,
    input  logic       btn_load,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] load_val,
    output logic [3:0] count,
    output logic       step,
    output logic       wrap,
    output logic [3:0] db_level
);

    localparam logic [6:0] DB_LAST = 7'(DEBOUNCE_TIME - 1);
    localparam logic [3:0] MAX_C   = 4'(MAX_COUNT);

    // Elaboration-time parameter range guard
    if (DEBOUNCE_TIME < 1 || DEBOUNCE_TIME > 127 || MAX_COUNT < 1 || MAX_COUNT > 15
        || REPEAT_TIME < 1) begin : g_param_err
        $error("count_ctrl: parameter out of legal range");
    end

    // Clamp a requested load value to the counter range
    function automatic logic [3:0] sat_load(input logic [3:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    // Channel order everywhere: {down, up, load, clr}
    logic [3:0] raw;
    logic [3:0] sync_p0, sync_p1;
    logic [3:0] db, db_prev;
    logic [6:0] db_cnt [4];
    logic [3:0] press_p2;
    logic [3:0] ev;
    logic       exec;
    logic [3:0] nxt_count;
    logic       nxt_wrap;
    logic       vld_p3, wrap_p3;

    assign raw      = {btn_down, btn_up, btn_load, btn_clr};
    assign db_level = db;

    // Two-flop synchronizer for the asynchronous button inputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stability counter per channel: db flips only after DEBOUNCE_TIME disagreeing samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            db <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= ~db[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 7'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Rising-edge detect of the debounced levels; releases produce nothing
    always_ff @(posedge CLK) begin
        if (RST) begin
            db_prev  <= '0;
            press_p2 <= '0;
        end else begin
            db_prev  <= db;
            press_p2 <= db & ~db_prev;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(4 * REPEAT_TIME + 1);
    localparam logic [RPT_W-1:0] LIM_FIRST = RPT_W'(4 * REPEAT_TIME - 1);
    localparam logic [RPT_W-1:0] LIM_NEXT  = RPT_W'(REPEAT_TIME - 1);

    logic [RPT_W-1:0] rpt_tmr;
    logic             rpt_first;
    logic [3:0]       rpt_ev;
    logic             held, hp_exec, ud_exec;

    assign held    = db[2] | db[3];
    assign hp_exec = ev[0] | ev[1];
    assign ud_exec = ev[2] | ev[3];

    // Repeat timer: restarts on every executed UP/DOWN event and emits synthetic presses
    always_ff @(posedge CLK) begin
        if (RST || !held || hp_exec) begin
            rpt_tmr   <= '0;
            rpt_first <= 1'b1;
            rpt_ev    <= '0;
        end else if (ud_exec) begin
            rpt_tmr   <= RPT_W'(1);
            rpt_first <= (rpt_ev == 4'b0000);
            rpt_ev    <= '0;
        end else begin
            rpt_tmr <= rpt_tmr + RPT_W'(1);
            if (rpt_tmr == (rpt_first ? LIM_FIRST : LIM_NEXT))
                rpt_ev <= db[2] ? 4'b0100 : 4'b1000;
            else
                rpt_ev <= '0;
        end
    end

    assign ev = press_p2 | rpt_ev;
`else
    assign ev = press_p2;
`endif

    assign exec = |ev;

    // Priority arbitration and next-count arithmetic for the winning command
    always_comb begin
        nxt_count = count;
        nxt_wrap  = 1'b0;
        if (ev[0]) begin
            nxt_count = '0;
        end else if (ev[1]) begin
            nxt_count = sat_load(load_val);
        end else if (ev[2]) begin
            if (count == MAX_C) begin
                nxt_count = '0;
                nxt_wrap  = 1'b1;
            end else begin
                nxt_count = count + 4'd1;
            end
        end else if (ev[3]) begin
            if (count == 4'd0) begin
                nxt_count = MAX_C;
                nxt_wrap  = 1'b1;
            end else begin
                nxt_count = count - 4'd1;
            end
        end
    end

    // Count register and the one-cycle-later step/wrap status pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            count   <= '0;
            vld_p3  <= 1'b0;
            wrap_p3 <= 1'b0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            if (exec) count <= nxt_count;
            vld_p3  <= exec;
            wrap_p3 <= nxt_wrap;
            step    <= vld_p3;
            wrap    <= wrap_p3;
        end
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Testbench for count_ctrl (DEBOUNCE_TIME=4, MAX_COUNT=9, REPEAT_TIME=8, default build).
module tb_count_ctrl;

    localparam int DT  = 4;
    localparam int MAX = 9;
    localparam int NE  = 1024;

    logic       clk = 1'b0;
    logic       RST;
    logic       btn_clr, btn_load, btn_up, btn_down;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       step, wrap;
    logic [3:0] db_level;

    int n_chk = 0;
    int n_err = 0;
    int ek = -1;

    logic [3:0] m_s1  [NE];
    logic [3:0] m_s2  [NE];
    logic [3:0] m_db  [NE];
    logic [3:0] m_pr  [NE];
    int         m_cnt [NE];
    logic       m_ex  [NE];
    logic       m_wr  [NE];
    logic       m_rst [NE];
    int         t_last [4];

    logic mon_on = 1'b0;
    logic glitch_seen = 1'b0;

    count_ctrl #(.DEBOUNCE_TIME(DT), .MAX_COUNT(MAX), .REPEAT_TIME(8)) dut (
        .CLK(clk), .RST(RST),
        .btn_clr(btn_clr), .btn_load(btn_load), .btn_up(btn_up), .btn_down(btn_down),
        .load_val(load_val),
        .count(count), .step(step), .wrap(wrap), .db_level(db_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, ek);
        end
    endtask

    // Behavioural model, advanced once per rising edge from the sampled inputs
    initial begin
        forever begin
            @(posedge clk);
            ek++;
            if (ek >= NE) begin
                $display("FAIL model_overrun: edge %0d beyond %0d", ek, NE);
                $fatal(1);
            end
            if (RST) begin
                m_s1[ek] = '0; m_s2[ek] = '0; m_db[ek] = '0; m_pr[ek] = '0;
                m_cnt[ek] = 0; m_ex[ek] = 1'b0; m_wr[ek] = 1'b0; m_rst[ek] = 1'b1;
                for (int c = 0; c < 4; c++) t_last[c] = ek;
            end else begin
                int c_val;
                logic [3:0] e;
                m_rst[ek] = 1'b0;
                m_s1[ek] = {btn_down, btn_up, btn_load, btn_clr};
                m_s2[ek] = m_s1[ek-1];
                // db flips once the synchronized input has disagreed with it on
                // DT consecutive edges since its last change (or reset)
                for (int c = 0; c < 4; c++) begin
                    logic cur, tog;
                    cur = m_db[ek-1][c];
                    tog = 1'b1;
                    for (int j = ek - DT + 1; j <= ek; j++) begin
                        if (j <= t_last[c]) tog = 1'b0;
                        else if (m_s2[j-1][c] == cur) tog = 1'b0;
                    end
                    m_db[ek][c] = tog ? ~cur : cur;
                    if (tog) t_last[c] = ek;
                end
                m_pr[ek] = m_db[ek-1] & ~m_db[ek-2];
                e = m_pr[ek-1];
                c_val = m_cnt[ek-1];
                m_ex[ek] = (e != 4'b0000);
                m_wr[ek] = 1'b0;
                if (e[0]) c_val = 0;
                else if (e[1]) c_val = (int'(load_val) > MAX) ? MAX : int'(load_val);
                else if (e[2]) begin
                    m_wr[ek] = (c_val == MAX);
                    c_val = (c_val + 1) % (MAX + 1);
                end else if (e[3]) begin
                    if (c_val == 0) begin
                        c_val = MAX;
                        m_wr[ek] = 1'b1;
                    end else c_val = c_val - 1;
                end
                m_cnt[ek] = c_val;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (ek >= 0) begin
                int xs, xw;
                xs = 0; xw = 0;
                if (!m_rst[ek] && ek >= 1) begin
                    xs = int'(m_ex[ek-1]);
                    xw = int'(m_wr[ek-1]);
                end
                check("count", int'(count), m_cnt[ek]);
                check("step", int'(step), xs);
                check("wrap", int'(wrap), xw);
                check("db_level", int'(db_level), int'(m_db[ek]));
                if (mon_on && (db_level[2] || step)) glitch_seen = 1'b1;
            end
        end
    end

    task automatic wait_to(input int e);
        while (ek < e) @(negedge clk);
    endtask

    task automatic set_btns(input logic [3:0] m);
        {btn_down, btn_up, btn_load, btn_clr} = m;
    endtask

    // Press with the given mask; step/wrap/count checked at the known latency
    task automatic press_chk(input string nm, input logic [3:0] mask,
                             input int exp_cnt, input int exp_wrap);
        int e0;
        e0 = ek;
        set_btns(mask);
        wait_to(e0 + 9);
        check({nm, "_step"}, int'(step), 1);
        check({nm, "_wrap"}, int'(wrap), exp_wrap);
        check({nm, "_count"}, int'(count), exp_cnt);
        wait_to(e0 + 10);
        check({nm, "_step_end"}, int'(step), 0);
        set_btns(4'b0000);
        wait_to(e0 + 26);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", ek);
        $fatal(1);
    end

    initial begin
        int r, r2;
        RST = 1'b1;
        set_btns(4'b0000);
        load_val = 4'd0;
        wait_to(3);
        RST = 1'b0;
        check("rst_count", int'(count), 0);
        check("rst_step", int'(step), 0);
        check("rst_db", int'(db_level), 0);

        // Single held press: raw stable from edge 10, count at 17, step at 18
        wait_to(9);
        btn_up = 1'b1;
        wait_to(16);
        check("t1_count16", int'(count), 0);
        wait_to(17);
        check("t1_count17", int'(count), 1);
        check("t1_model17", m_cnt[17], 1);
        check("t1_step17", int'(step), 0);
        wait_to(18);
        check("t1_step18", int'(step), 1);
        wait_to(19);
        check("t1_step19", int'(step), 0);
        wait_to(29);
        btn_up = 1'b0;
        wait_to(50);
        check("t1_single", int'(count), 1);

        // Short glitches never reach the debounced level
        mon_on = 1'b1;
        for (int g = 0; g < 5; g++) begin
            btn_up = 1'b1;
            repeat (3) @(negedge clk);
            btn_up = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        mon_on = 1'b0;
        check("t2_glitch_seen", int'(glitch_seen), 0);
        check("t2_count", int'(count), 1);

        // Wrap in both directions
        load_val = 4'd9;
        press_chk("t3_load9", 4'b0010, 9, 0);
        press_chk("t3_up_wrap", 4'b0100, 0, 1);
        press_chk("t3_down_wrap", 4'b1000, 9, 1);
        press_chk("t3_down", 4'b1000, 8, 0);

        // CLR and UP in the same cycle: clear wins, no increment afterwards
        load_val = 4'd5;
        press_chk("t4_load5", 4'b0010, 5, 0);
        press_chk("t4_clr_up", 4'b0101, 0, 0);
        check("t4_after", int'(count), 0);

        // Load saturation
        load_val = 4'd12;
        press_chk("t5_load12", 4'b0010, 9, 0);
        load_val = 4'd3;
        press_chk("t5_load3", 4'b0010, 3, 0);

        // Reset in the middle of debouncing discards the partial count
        r = ek + 5;
        btn_up = 1'b1;
        wait_to(r - 1);
        RST = 1'b1;
        wait_to(r);
        RST = 1'b0;
        check("t6_rst_count", int'(count), 0);
        wait_to(r + 7);
        check("t6_count7", int'(count), 0);
        wait_to(r + 8);
        check("t6_count8", int'(count), 1);
        wait_to(r + 9);
        check("t6_step9", int'(step), 1);
        wait_to(r + 20);
        check("t6_held", int'(count), 1);

        // Button still held across reset release re-debounces as a new press
        RST = 1'b1;
        wait_to(r + 21);
        RST = 1'b0;
        r2 = r + 21;
        check("t6_rst2_count", int'(count), 0);
        check("t6_rst2_db", int'(db_level), 0);
        wait_to(r2 + 8);
        check("t6_repress", int'(count), 1);
        wait_to(r2 + 9);
        check("t6_repress_step", int'(step), 1);
        btn_up = 1'b0;
        wait_to(r2 + 30);
        check("t6_final", int'(count), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
